rgb_led_scheduler: RTL
======================

RGB_LED_SCHEDULER -- requirements
Module: rgb_led_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 48000, meaning clk48 cycles per 1 ms timing tick.
REQ-002 SHALL have parameter GAP_MS, default 1, meaning LED-off ms inserted between consecutive jobs (0 = no gap).
REQ-003 SHALL have parameter NUM_REQ, default 3, meaning number of requesters.
REQ-004 clk48  in  1  sole clock, 48 MHz.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester job request.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; transfer when valid&ready.
REQ-008 req_color  in  24*NUM_REQ  per-requester {r[7:0],g[7:0],b[7:0]} duty; requester i at bits [24i+23:24i].
REQ-009 req_dur_ms  in  16*NUM_REQ  per-requester show duration in ms; requester i at bits [16i+15:16i].
REQ-010 grant  out  NUM_REQ  one-hot owner of the running job; all-zero when idle.
REQ-011 busy  out  1  high in SHOW or GAP.
REQ-012 rgb_led0_r, rgb_led0_g, rgb_led0_b  out  1 each  LED drives, active-low (0 = lit).

Function
REQ-013 SHALL implement states IDLE, SHOW, GAP.
REQ-014 IDLE: req_ready SHALL be high (combinationally) for the lowest-index requester with req_valid high, zero for all others.
REQ-015 On a transfer, color and duration SHALL be captured, grant set to the winner, and state SHALL move to SHOW the next cycle.
REQ-016 A requester dropping req_valid before transfer SHALL be legal; nothing is captured.
REQ-017 Duration 0 SHALL be treated as 1 ms.
REQ-018 Ms prescaler SHALL clear on SHOW and GAP entry; a tick occurs every TICK_DIV cycles thereafter.
REQ-019 SHOW SHALL last exactly dur*TICK_DIV cycles, then go to GAP if GAP_MS>0, else IDLE.
REQ-020 GAP SHALL last exactly GAP_MS*TICK_DIV cycles with all LEDs off, then go to IDLE.
REQ-021 grant SHALL hold its value through SHOW and clear on GAP entry (or IDLE entry if GAP_MS=0).
REQ-022 8-bit PWM counter SHALL free-run, wrapping 255->0 and incrementing every cycle.
REQ-023 In SHOW, channel lit when pwm_cnt < duty; duty 0 never lit, duty 255 lit 255 of 256 cycles.
REQ-024 LED outputs SHALL be registered (one-cycle latency from pwm_cnt compare); outside SHOW all three SHALL be 1.
REQ-025 Arbitration SHALL be fixed priority with no starvation guarantee; new requests are considered only in IDLE.
REQ-026 Minimum spacing between back-to-back jobs with GAP_MS=0 SHALL be one IDLE cycle.

Reset
REQ-027 rst SHALL force, on the next clk48 edge: state IDLE; prescaler, duration counter, and pwm_cnt 0; grant 0; busy 0; req_ready 0 for the same cycle; LED outputs 1.
REQ-028 rst asserted mid-SHOW or mid-GAP SHALL abort the job without completing it; the job is not replayed.
REQ-029 While rst is high, no transfer SHALL occur.

Structure
REQ-030 Package rgb_led_pkg SHALL hold the state enum, the color struct (r, g, b bytes), and the PWM_BITS=8 constant.
REQ-031 One sub-module, led_pwm_channel (duty in, pwm_cnt in, enable in, registered active-low out), SHALL be instantiated three times.

Verification
REQ-032 Bench runs with TICK_DIV=4, GAP_MS=1.
REQ-033 Single job: req 0, color FF0000, dur 2 -> ready0 high 1 cycle; busy 8 cycles SHOW + 4 cycles GAP; r lit 255/256 duty; g and b constant 1.
REQ-034 Contention: valid on req 0 and req 2 in the same cycle -> req 0 granted first; req 2 granted in the first IDLE cycle after GAP.
REQ-035 Duty extremes: color 00_80_FF -> r never 0; g low 128 of 256 cycles; b low 255 of 256 cycles.
REQ-036 dur 0 -> SHOW lasts 4 cycles.
REQ-037 rst pulse in SHOW cycle 3 -> next cycle IDLE, LEDs 1, grant 0; a pending req 1 is accepted after rst deasserts.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED job scheduler.
package rgb_led_pkg;

    localparam int PWM_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM colour channel: registered, active-low drive lit while pwm_cnt < duty.
module led_pwm_channel
    import rgb_led_pkg::*;
(
    input  logic                clk48,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                enable,
    output logic                led_n
);

    logic led_n_d;
    logic led_n_q;

    always_comb begin
        led_n_d = ~(enable && (pwm_cnt < duty));
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            led_n_q <= 1'b1;
        end else begin
            led_n_q <= led_n_d;
        end
    end

    assign led_n = led_n_q;

endmodule

// File: rtl/rgb_led_scheduler.sv
// Fixed-priority scheduler that shows one requester's colour for a timed
// number of milliseconds, followed by an optional LED-off gap.
module rgb_led_scheduler
    import rgb_led_pkg::*;
#(
    parameter int TICK_DIV = 48000,
    parameter int GAP_MS   = 1,
    parameter int NUM_REQ  = 3
) (
    input  logic                  clk48,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [24*NUM_REQ-1:0] req_color,
    input  logic [16*NUM_REQ-1:0] req_dur_ms,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  rgb_led0_r,
    output logic                  rgb_led0_g,
    output logic                  rgb_led0_b,
    output logic [1:0]            dbg_state
);

    // Handshake: a job transfers on the edge where req_valid[i] & req_ready[i];
    // ready is offered only in IDLE, only to the lowest-index valid requester.

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [15:0]          ms_q, ms_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    color_t               color_q, color_d;
    logic [PWM_BITS-1:0]  pwm_q, pwm_d;

    logic [NUM_REQ-1:0]   win_onehot;
    color_t               sel_color;
    logic [15:0]          sel_dur;
    logic                 tick;
    logic                 show_next;

    always_comb begin
        win_onehot = req_valid & (~req_valid + NUM_REQ'(1));
        sel_color  = '0;
        sel_dur    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_color = req_color[24*i +: 24];
                sel_dur   = req_dur_ms[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ms_d      = ms_q;
        grant_d   = grant_q;
        color_d   = color_q;
        pwm_d     = pwm_q + PWM_BITS'(1);
        req_ready = '0;
        tick      = (presc_q == TICK_LAST);

        case (state_q)
            ST_IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready = win_onehot;
                    grant_d   = win_onehot;
                    color_d   = sel_color;
                    ms_d      = (sel_dur == 16'd0) ? 16'd1 : sel_dur;
                    presc_d   = '0;
                    state_d   = ST_SHOW;
                end
            end
            ST_SHOW, ST_GAP: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    ms_d = ms_q - 16'd1;
                    if (ms_q == 16'd1) begin
                        grant_d = '0;
                        if (state_q == ST_SHOW && GAP_MS > 0) begin
                            state_d = ST_GAP;
                            ms_d    = 16'(GAP_MS);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        // Registering against the next state keeps the LEDs exactly aligned with SHOW.
        show_next = !rst && (state_d == ST_SHOW);
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            ms_q    <= '0;
            grant_q <= '0;
            color_q <= '0;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            grant_q <= grant_d;
            color_q <= color_d;
            pwm_q   <= pwm_d;
        end
    end

    led_pwm_channel u_ch_r (
        .clk48   (clk48),
        .rst     (rst),
        .duty    (color_d.r),
        .pwm_cnt (pwm_q),
        .enable  (show_next),
        .led_n   (rgb_led0_r)
    );

    led_pwm_channel u_ch_g (
        .clk48   (clk48),
        .rst     (rst),
        .duty    (color_d.g),
        .pwm_cnt (pwm_q),
        .enable  (show_next),
        .led_n   (rgb_led0_g)
    );

    led_pwm_channel u_ch_b (
        .clk48   (clk48),
        .rst     (rst),
        .duty    (color_d.b),
        .pwm_cnt (pwm_q),
        .enable  (show_next),
        .led_n   (rgb_led0_b)
    );

    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
